apb_protocol_checker: RTL and testbench
=======================================

Name: apb_protocol_checker

Overview:
Synthesizable, parametrised APB (v2/AMBA4) protocol checker that passively monitors one slave's APB port. It tracks the phase with an FSM, supports PREADY wait states, and detects eight protocol and decode violations. It reports violations as per-violation pulses, sticky flags and a maskable interrupt, and keeps transfer, error and max-wait statistics. It sits beside any APB slave in RTL, or in emulation builds where SVA is unavailable.

Parameters:
ADDR_WIDTH, 32, PADDR width
DATA_WIDTH, 32, PWDATA width; PSTRB width is DATA_WIDTH/8
MEM_DEPTH, 256, number of valid word addresses; PADDR >= MEM_DEPTH is out of range
TIMEOUT_CYCLES, 16, wait-state count that triggers the timeout violation (>=1)
STRICT_ERR, 1, 1 = PSLVERR on an in-range access is a violation
CNT_WIDTH, 16, width of the statistics counters
WAIT_WIDTH, 8, width of the wait counter and max-wait register (2**WAIT_WIDTH > TIMEOUT_CYCLES)

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
PSEL, PENABLE, PWRITE, PREADY, PSLVERR  in  1 each  monitored APB signals
PADDR  in  ADDR_WIDTH  monitored address
PWDATA  in  DATA_WIDTH  monitored write data
PSTRB  in  DATA_WIDTH/8  monitored strobes
clr_i  in  1  synchronous clear of sticky flags and statistics
irq_mask_i  in  8  per-violation interrupt enable
viol_pulse_o  out  8  one-cycle violation pulses, bit index = violation ID
viol_sticky_o  out  8  sticky violation flags
irq_o  out  1  |(viol_sticky_o & irq_mask_i), registered
busy_o  out  1  FSM not in IDLE
xfer_cnt_o  out  CNT_WIDTH  completed transfers, saturating
err_cnt_o  out  CNT_WIDTH  completions with PSLVERR=1, saturating
max_wait_o  out  WAIT_WIDTH  largest wait-state count of any completed transfer, saturating

Behaviour:
- Reset: PRESETn low asynchronously sets the FSM to IDLE and clears every output and internal register to 0. A transfer cut by reset is discarded, with no violation and no count.
- At each PCLK rising edge the checker classifies the sampled bus using the current state. All outputs are registered, so a pulse or flag appears in the cycle after the offending bus cycle.
- States: IDLE, SETUP, ACCESS. A completion is the sampled cycle ACCESS && PSEL && PENABLE && PREADY.
- IDLE:
  - PSEL && !PENABLE: go to SETUP; capture PADDR, PWRITE, PWDATA, PSTRB; clear the wait counter.
  - PSEL && PENABLE: V0 ENABLE_NO_SETUP; stay IDLE.
  - !PSEL: stay IDLE.
- SETUP (sampled cycle must be the first ACCESS cycle):
  - !PSEL or !PENABLE: V1 NO_ACCESS_PHASE; go IDLE. If PSEL && !PENABLE, treat it as a new SETUP and recapture.
  - Otherwise go to ACCESS and evaluate the ACCESS rules on this same sample.
- ACCESS rules:
  - Any captured field differs from the live value: V2 UNSTABLE. PWDATA and PSTRB are compared only when PWRITE=1.
  - !PSEL or !PENABLE before completion: V3 ABORT; go IDLE.
  - PREADY=0: increment the wait counter (saturating). When it reaches TIMEOUT_CYCLES, raise V4 TIMEOUT once per transfer and keep monitoring.
  - Completion:
    - increment xfer_cnt; increment err_cnt if PSLVERR; update max_wait;
    - V5 RANGE_NO_ERR if captured PADDR >= MEM_DEPTH and PSLVERR=0;
    - V6 ERR_IN_RANGE if STRICT_ERR and PADDR < MEM_DEPTH and PSLVERR=1;
    - V7 READ_STRB if PWRITE=0 and PSTRB != 0;
    - go IDLE. A back-to-back SETUP is recognised on the next sample.
- V7 also fires on PSLVERR=1 in any sampled cycle that is not a completion (spurious error).
- Multiple violations in one cycle set all corresponding bits.
- clr_i clears sticky flags and counters at the edge. If a violation is detected at the same edge, its sticky bit stays set (set wins) and the counters take their post-clear value plus that cycle's increment.
- Counters saturate at all-ones; no wrap.

Test Plan:
- Write: addr 0x10, PWDATA 0xA5A5A5A5, PSTRB 0xF, 2 wait states, PSLVERR=0 -> no pulses; xfer_cnt=1; max_wait=2; busy_o high for 3 cycles.
- Read: addr 300, PSLVERR=0 -> viol_pulse_o[5] for one cycle, then viol_sticky_o=0x20; with irq_mask_i=0x20, irq_o=1. Repeat with PSLVERR=1 -> no violation, err_cnt=1.
- PADDR changes 0x10->0x14 during a wait state -> pulse bit 2. PSEL dropped in ACCESS with PREADY=0 -> pulse bit 3, FSM returns to IDLE.
- PREADY held low for 20 cycles (TIMEOUT_CYCLES=16) -> a single pulse on bit 4 in the cycle after the 16th wait state; completion at cycle 21; max_wait=20.
- PSEL=PENABLE=1 from IDLE -> bit 0. SETUP followed by PENABLE=0 -> bit 1. Read with PSTRB=0x3 -> bit 7.
- PRESETn asserted during a wait state -> all outputs 0 immediately. Separately, clr_i coincident with a V0 event -> viol_sticky_o=0x01 and counters zero.

Source files
------------

// File: rtl/apb_protocol_checker.sv
// apb_protocol_checker: passive APB (v2/AMBA4) monitor for a single slave port.
// Tracks the transfer phase and flags eight protocol/decode violations:
//   0 ENABLE_NO_SETUP  1 NO_ACCESS_PHASE  2 UNSTABLE   3 ABORT
//   4 TIMEOUT          5 RANGE_NO_ERR     6 ERR_IN_RANGE 7 READ_STRB / spurious PSLVERR
// Ports:
//   PCLK, PRESETn                 clock, async active-low reset
//   PSEL..PSTRB                   monitored APB signals (inputs only)
//   clr_i                         sync clear of sticky flags and statistics
//   irq_mask_i                    per-violation interrupt enable
//   viol_pulse_o / viol_sticky_o  one-cycle and sticky violation flags
//   irq_o                         |(sticky & mask)
//   busy_o                        FSM not in IDLE
//   xfer_cnt_o, err_cnt_o         saturating completion / PSLVERR counters
//   max_wait_o                    largest wait-state count of a completed transfer
module apb_protocol_checker #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_DEPTH      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned STRICT_ERR     = 1,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned WAIT_WIDTH     = 8
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic                    clr_i,
  input  logic [7:0]              irq_mask_i,
  output logic [7:0]              viol_pulse_o,
  output logic [7:0]              viol_sticky_o,
  output logic                    irq_o,
  output logic                    busy_o,
  output logic [CNT_WIDTH-1:0]    xfer_cnt_o,
  output logic [CNT_WIDTH-1:0]    err_cnt_o,
  output logic [WAIT_WIDTH-1:0]   max_wait_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [WAIT_WIDTH-1:0] TIMEOUT_W  = WAIT_WIDTH'(TIMEOUT_CYCLES);

  // Fields latched in SETUP that must hold for the whole ACCESS phase
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strb;
  } cap_t;

  logic [1:0]            state, state_n;
  cap_t                  cap, cap_n, live;
  logic [WAIT_WIDTH-1:0] wait_cnt, wait_n;
  logic [7:0]            viol_c, sticky_n;
  logic                  irq_n, busy_n;
  logic [CNT_WIDTH-1:0]  xfer_n, err_n, xfer_base, err_base;
  logic [WAIT_WIDTH-1:0] max_n, max_base;
  logic                  eval_c, cmpl_c, unstable_c, oor_c;

  assign live = {PADDR, PWRITE, PWDATA, PSTRB};

  // Write data/strobes only matter for writes; address and direction always
  assign unstable_c = (cap.addr != PADDR) || (cap.write != PWRITE) ||
                      (cap.write && ((cap.wdata != PWDATA) || (cap.strb != PSTRB)));
  assign oor_c      = (cap.addr >= ADDR_LIMIT);

  // Registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state         <= ST_IDLE;
      cap           <= '0;
      wait_cnt      <= '0;
      viol_pulse_o  <= '0;
      viol_sticky_o <= '0;
      irq_o         <= 1'b0;
      busy_o        <= 1'b0;
      xfer_cnt_o    <= '0;
      err_cnt_o     <= '0;
      max_wait_o    <= '0;
    end else begin
      state         <= state_n;
      cap           <= cap_n;
      wait_cnt      <= wait_n;
      viol_pulse_o  <= viol_c;
      viol_sticky_o <= sticky_n;
      irq_o         <= irq_n;
      busy_o        <= busy_n;
      xfer_cnt_o    <= xfer_n;
      err_cnt_o     <= err_n;
      max_wait_o    <= max_n;
    end
  end

  // Phase tracking, violation classification and statistics update
  always_comb begin
    state_n = state;
    cap_n   = cap;
    wait_n  = wait_cnt;
    viol_c  = '0;
    eval_c  = 1'b0;
    cmpl_c  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_n = ST_SETUP;
          cap_n   = live;
          wait_n  = '0;
        end else if (PSEL && PENABLE) begin
          viol_c[0] = 1'b1;
        end
      end
      ST_SETUP: begin
        if (!PSEL || !PENABLE) begin
          viol_c[1] = 1'b1;
          state_n   = ST_IDLE;
          // A repeated SETUP cycle restarts the transfer with fresh fields
          if (PSEL) begin
            state_n = ST_SETUP;
            cap_n   = live;
            wait_n  = '0;
          end
        end else begin
          eval_c = 1'b1;
        end
      end
      ST_ACCESS: eval_c = 1'b1;
      default:   state_n = ST_IDLE;
    endcase

    // ACCESS rules; also applied to the first ACCESS sample seen from SETUP
    if (eval_c) begin
      state_n   = ST_ACCESS;
      viol_c[2] = unstable_c;
      if (!PSEL || !PENABLE) begin
        viol_c[3] = 1'b1;
        state_n   = ST_IDLE;
      end else if (!PREADY) begin
        if (wait_cnt != '1) wait_n = wait_cnt + WAIT_WIDTH'(1);
        // Counter saturates above the threshold, so this fires once per transfer
        viol_c[4] = (wait_n == TIMEOUT_W) && (wait_cnt != TIMEOUT_W);
      end else begin
        cmpl_c    = 1'b1;
        state_n   = ST_IDLE;
        viol_c[5] = oor_c && !PSLVERR;
        viol_c[6] = (STRICT_ERR != 0) && !oor_c && PSLVERR;
        viol_c[7] = !cap.write && (cap.strb != '0);
      end
    end

    // PSLVERR outside a completion is spurious
    if (PSLVERR && !cmpl_c) viol_c[7] = 1'b1;

    // Clear first, then apply this cycle's events so set wins
    sticky_n  = (clr_i ? 8'h00 : viol_sticky_o) | viol_c;
    irq_n     = |(sticky_n & irq_mask_i);
    busy_n    = (state_n != ST_IDLE);

    xfer_base = clr_i ? '0 : xfer_cnt_o;
    err_base  = clr_i ? '0 : err_cnt_o;
    max_base  = clr_i ? '0 : max_wait_o;

    xfer_n = xfer_base;
    err_n  = err_base;
    max_n  = max_base;
    if (cmpl_c && (xfer_base != '1))           xfer_n = xfer_base + CNT_WIDTH'(1);
    if (cmpl_c && PSLVERR && (err_base != '1)) err_n  = err_base + CNT_WIDTH'(1);
    if (cmpl_c && (wait_cnt > max_base))       max_n  = wait_cnt;
  end

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Directed self-checking bench for apb_protocol_checker.
module tb_apb_protocol_checker;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic        clr_i;
  logic [7:0]  irq_mask_i;
  logic [7:0]  viol_pulse_o, viol_sticky_o;
  logic        irq_o, busy_o;
  logic [15:0] xfer_cnt_o, err_cnt_o;
  logic [7:0]  max_wait_o;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] pulse_acc;
  int busy_cnt;

  apb_protocol_checker #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .TIMEOUT_CYCLES(16),
    .STRICT_ERR(1), .CNT_WIDTH(16), .WAIT_WIDTH(8)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PREADY(PREADY), .PSLVERR(PSLVERR), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .clr_i(clr_i), .irq_mask_i(irq_mask_i),
    .viol_pulse_o(viol_pulse_o), .viol_sticky_o(viol_sticky_o), .irq_o(irq_o),
    .busy_o(busy_o), .xfer_cnt_o(xfer_cnt_o), .err_cnt_o(err_cnt_o),
    .max_wait_o(max_wait_o)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic bus_idle;
    PSEL = 1'b0; PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
  endtask

  task automatic do_clr;
    bus_idle();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  // Full transfer: SETUP, `waits` wait states, completion. Outputs left showing
  // the completion sample; pulse_acc/busy_cnt summarise the whole transfer.
  task automatic apb_xfer(input logic [31:0] a, input logic wr, input logic [31:0] d,
                          input logic [3:0] s, input int waits, input logic err);
    pulse_acc = 8'h00; busy_cnt = 0;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = wr; PWDATA = d; PSTRB = s;
    PREADY = 1'b0; PSLVERR = 1'b0;
    tick(); pulse_acc |= viol_pulse_o; busy_cnt += int'(busy_o);
    PENABLE = 1'b1;
    for (int i = 0; i < waits; i++) begin
      tick(); pulse_acc |= viol_pulse_o; busy_cnt += int'(busy_o);
    end
    PREADY = 1'b1; PSLVERR = err;
    tick(); pulse_acc |= viol_pulse_o; busy_cnt += int'(busy_o);
    bus_idle();
  endtask

  task automatic test_reset;
    PRESETn = 1'b0; clr_i = 1'b0; irq_mask_i = 8'h00;
    bus_idle(); PADDR = '0; PWRITE = 1'b0; PWDATA = '0; PSTRB = '0;
    tick(); tick();
    n_vec++;
    if ({viol_pulse_o, viol_sticky_o, irq_o, busy_o, xfer_cnt_o, err_cnt_o, max_wait_o} !== 58'd0) begin
      n_err++; $display("FAIL reset_outputs: got pulse=%h sticky=%h irq=%b busy=%b xfer=%0d err=%0d max=%0d want all 0",
                        viol_pulse_o, viol_sticky_o, irq_o, busy_o, xfer_cnt_o, err_cnt_o, max_wait_o);
    end
    PRESETn = 1'b1;
    tick();
  endtask

  task automatic test_write;
    apb_xfer(32'h10, 1'b1, 32'hA5A5_A5A5, 4'hF, 2, 1'b0);
    n_vec++; if (pulse_acc !== 8'h00) begin n_err++; $display("FAIL write_pulses: got %h want 00", pulse_acc); end
    n_vec++; if (busy_cnt !== 3) begin n_err++; $display("FAIL write_busy_cycles: got %0d want 3", busy_cnt); end
    n_vec++; if (xfer_cnt_o !== 16'd1) begin n_err++; $display("FAIL write_xfer_cnt: got %0d want 1", xfer_cnt_o); end
    n_vec++; if (max_wait_o !== 8'd2) begin n_err++; $display("FAIL write_max_wait: got %0d want 2", max_wait_o); end
    n_vec++; if (err_cnt_o !== 16'd0) begin n_err++; $display("FAIL write_err_cnt: got %0d want 0", err_cnt_o); end
    tick();
  endtask

  task automatic test_read_range;
    irq_mask_i = 8'h20;
    apb_xfer(32'd300, 1'b0, 32'h0, 4'h0, 0, 1'b0);
    n_vec++; if (viol_pulse_o !== 8'h20) begin n_err++; $display("FAIL range_pulse: got %h want 20", viol_pulse_o); end
    tick();
    n_vec++; if (viol_pulse_o !== 8'h00) begin n_err++; $display("FAIL range_pulse_clear: got %h want 00", viol_pulse_o); end
    n_vec++; if (viol_sticky_o !== 8'h20) begin n_err++; $display("FAIL range_sticky: got %h want 20", viol_sticky_o); end
    n_vec++; if (irq_o !== 1'b1) begin n_err++; $display("FAIL range_irq: got %b want 1", irq_o); end
    n_vec++; if (xfer_cnt_o !== 16'd2) begin n_err++; $display("FAIL range_xfer_cnt: got %0d want 2", xfer_cnt_o); end
    do_clr();
    n_vec++; if ({viol_sticky_o, irq_o, xfer_cnt_o} !== 25'd0) begin
      n_err++; $display("FAIL clr_state: got sticky=%h irq=%b xfer=%0d want 0", viol_sticky_o, irq_o, xfer_cnt_o); end
    apb_xfer(32'd300, 1'b0, 32'h0, 4'h0, 0, 1'b1);
    n_vec++; if (pulse_acc !== 8'h00) begin n_err++; $display("FAIL range_err_pulses: got %h want 00", pulse_acc); end
    n_vec++; if (err_cnt_o !== 16'd1) begin n_err++; $display("FAIL range_err_cnt: got %0d want 1", err_cnt_o); end
    n_vec++; if (xfer_cnt_o !== 16'd1) begin n_err++; $display("FAIL range_err_xfer: got %0d want 1", xfer_cnt_o); end
    tick();
  endtask

  task automatic test_unstable_abort;
    do_clr();
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h10; PWRITE = 1'b1; PWDATA = 32'h1; PSTRB = 4'hF;
    tick();
    PENABLE = 1'b1; PREADY = 1'b0;
    tick();
    n_vec++; if (viol_pulse_o !== 8'h00) begin n_err++; $display("FAIL stable_wait: got %h want 00", viol_pulse_o); end
    PADDR = 32'h14;
    tick();
    n_vec++; if (viol_pulse_o !== 8'h04) begin n_err++; $display("FAIL unstable_pulse: got %h want 04", viol_pulse_o); end
    PADDR = 32'h10; PREADY = 1'b1;
    tick();
    n_vec++; if (viol_pulse_o !== 8'h00) begin n_err++; $display("FAIL unstable_cmpl: got %h want 00", viol_pulse_o); end
    n_vec++; if (xfer_cnt_o !== 16'd1) begin n_err++; $display("FAIL unstable_xfer: got %0d want 1", xfer_cnt_o); end
    bus_idle(); tick();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 4'h0;
    tick();
    PENABLE = 1'b1; PREADY = 1'b0;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
    tick();
    n_vec++; if (viol_pulse_o !== 8'h08) begin n_err++; $display("FAIL abort_pulse: got %h want 08", viol_pulse_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy_o); end
    n_vec++; if (viol_sticky_o !== 8'h0C) begin n_err++; $display("FAIL abort_sticky: got %h want 0C", viol_sticky_o); end
    n_vec++; if (xfer_cnt_o !== 16'd1) begin n_err++; $display("FAIL abort_xfer: got %0d want 1", xfer_cnt_o); end
    tick();
  endtask

  task automatic test_timeout;
    int to_cnt = 0;
    int to_at = 0;
    logic [7:0] acc = 8'h00;
    do_clr();
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h40; PWRITE = 1'b1; PWDATA = 32'h5; PSTRB = 4'h1;
    tick();
    PENABLE = 1'b1; PREADY = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      acc |= viol_pulse_o;
      if (viol_pulse_o[4]) begin to_cnt++; to_at = i; end
    end
    n_vec++; if (to_cnt !== 1) begin n_err++; $display("FAIL timeout_count: got %0d want 1", to_cnt); end
    n_vec++; if (to_at !== 16) begin n_err++; $display("FAIL timeout_cycle: got %0d want 16", to_at); end
    n_vec++; if (acc !== 8'h10) begin n_err++; $display("FAIL timeout_other_bits: got %h want 10", acc); end
    PREADY = 1'b1;
    tick();
    n_vec++; if (viol_pulse_o !== 8'h00) begin n_err++; $display("FAIL timeout_cmpl: got %h want 00", viol_pulse_o); end
    n_vec++; if (max_wait_o !== 8'd20) begin n_err++; $display("FAIL timeout_max_wait: got %0d want 20", max_wait_o); end
    n_vec++; if (xfer_cnt_o !== 16'd1) begin n_err++; $display("FAIL timeout_xfer: got %0d want 1", xfer_cnt_o); end
    bus_idle(); tick();
  endtask

  task automatic test_phase_decode;
    do_clr();
    PSEL = 1'b1; PENABLE = 1'b1; PADDR = 32'h10; PWRITE = 1'b0; PSTRB = 4'h0;
    tick();
    n_vec++; if (viol_pulse_o !== 8'h01) begin n_err++; $display("FAIL v0_pulse: got %h want 01", viol_pulse_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL v0_busy: got %b want 0", busy_o); end
    bus_idle(); tick();
    PSEL = 1'b1; PENABLE = 1'b0;
    tick();
    PSEL = 1'b0;
    tick();
    n_vec++; if (viol_pulse_o !== 8'h02) begin n_err++; $display("FAIL v1_pulse: got %h want 02", viol_pulse_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL v1_busy: got %b want 0", busy_o); end
    bus_idle(); tick();
    apb_xfer(32'h20, 1'b0, 32'h0, 4'h3, 0, 1'b0);
    n_vec++; if (viol_pulse_o !== 8'h80) begin n_err++; $display("FAIL v7_read_strb: got %h want 80", viol_pulse_o); end
    PSLVERR = 1'b1;
    tick();
    n_vec++; if (viol_pulse_o !== 8'h80) begin n_err++; $display("FAIL v7_spurious: got %h want 80", viol_pulse_o); end
    bus_idle(); tick();
    apb_xfer(32'd255, 1'b0, 32'h0, 4'h0, 0, 1'b1);
    n_vec++; if (viol_pulse_o !== 8'h40) begin n_err++; $display("FAIL v6_last_word: got %h want 40", viol_pulse_o); end
    apb_xfer(32'd256, 1'b0, 32'h0, 4'h0, 0, 1'b0);
    n_vec++; if (viol_pulse_o !== 8'h20) begin n_err++; $display("FAIL v5_first_oor: got %h want 20", viol_pulse_o); end
    apb_xfer(32'd255, 1'b0, 32'h0, 4'h0, 0, 1'b0);
    n_vec++; if (viol_pulse_o !== 8'h00) begin n_err++; $display("FAIL in_range_ok: got %h want 00", viol_pulse_o); end
    apb_xfer(32'd300, 1'b0, 32'h0, 4'h3, 1, 1'b0);
    n_vec++; if (viol_pulse_o !== 8'hA0) begin n_err++; $display("FAIL multi_viol: got %h want A0", viol_pulse_o); end
    n_vec++; if (viol_sticky_o !== 8'hE3) begin n_err++; $display("FAIL sticky_accum: got %h want E3", viol_sticky_o); end
    n_vec++; if ({xfer_cnt_o, err_cnt_o} !== {16'd5, 16'd1}) begin
      n_err++; $display("FAIL decode_counts: got xfer=%0d err=%0d want 5/1", xfer_cnt_o, err_cnt_o); end
    tick();
  endtask

  task automatic test_reset_mid;
    irq_mask_i = 8'hFF;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h10; PWRITE = 1'b1; PWDATA = 32'h7; PSTRB = 4'hF;
    tick();
    PENABLE = 1'b1; PREADY = 1'b0;
    tick(); tick();
    PRESETn = 1'b0;
    #1;
    n_vec++;
    if ({viol_pulse_o, viol_sticky_o, irq_o, busy_o, xfer_cnt_o, err_cnt_o, max_wait_o} !== 58'd0) begin
      n_err++; $display("FAIL reset_mid_outputs: got pulse=%h sticky=%h irq=%b busy=%b xfer=%0d err=%0d max=%0d want all 0",
                        viol_pulse_o, viol_sticky_o, irq_o, busy_o, xfer_cnt_o, err_cnt_o, max_wait_o);
    end
    PRESETn = 1'b1;
    bus_idle();
    tick();
    n_vec++; if ({viol_pulse_o, busy_o, xfer_cnt_o} !== 25'd0) begin
      n_err++; $display("FAIL reset_mid_after: got pulse=%h busy=%b xfer=%0d want 0", viol_pulse_o, busy_o, xfer_cnt_o); end
  endtask

  task automatic test_clr_collision;
    apb_xfer(32'h10, 1'b1, 32'h1234_5678, 4'hF, 1, 1'b1);
    n_vec++; if ({xfer_cnt_o, err_cnt_o, max_wait_o} !== {16'd1, 16'd1, 8'd1}) begin
      n_err++; $display("FAIL pre_clr_counts: got xfer=%0d err=%0d max=%0d want 1/1/1", xfer_cnt_o, err_cnt_o, max_wait_o); end
    tick();
    PSEL = 1'b1; PENABLE = 1'b1; clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    n_vec++; if (viol_sticky_o !== 8'h01) begin n_err++; $display("FAIL clr_set_wins: got %h want 01", viol_sticky_o); end
    n_vec++; if ({xfer_cnt_o, err_cnt_o, max_wait_o} !== 40'd0) begin
      n_err++; $display("FAIL clr_counters: got xfer=%0d err=%0d max=%0d want 0", xfer_cnt_o, err_cnt_o, max_wait_o); end
    n_vec++; if (viol_pulse_o !== 8'h01) begin n_err++; $display("FAIL clr_v0_pulse: got %h want 01", viol_pulse_o); end
    bus_idle(); tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_range();
    test_unstable_abort();
    test_timeout();
    test_phase_decode();
    test_reset_mid();
    test_clr_collision();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
